// File: rtl/fft_frame_packer_if.sv
// AXI-Stream style link from the frame packer to the FFT core's data input.
interface fft_frame_packer_if #(
  parameter int TDATA_WIDTH = 16
) ();
  logic [TDATA_WIDTH-1:0] fft_data;
  logic                   fft_valid;
  logic                   fft_ready;
  logic                   fft_last;

  modport master (output fft_data, output fft_valid, output fft_last, input fft_ready);
  modport slave  (input fft_data, input fft_valid, input fft_last, output fft_ready);
endinterface

// File: rtl/fft_frame_packer.sv
// Circular-buffer framer: emits overlapping FFT_LEN-point frames every HOP samples
// onto an AXI-Stream link with backpressure, tlast and a sticky overrun flag.
module fft_frame_packer #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int TDATA_WIDTH  = 16,
  parameter int FFT_LEN_LOG2 = 12,
  parameter int HOP          = 2048
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic signed [SAMPLE_WIDTH-1:0] in_sample,
  input  logic                           audio_sample_valid,
  fft_frame_packer_if.master             fft,
  output logic [15:0]                    frame_count,
  output logic                           overrun
);
  localparam int FFT_LEN = 1 << FFT_LEN_LOG2;
  localparam int AW      = FFT_LEN_LOG2 + 1;
  localparam int DEPTH   = 1 << AW;
  localparam int PW      = AW + 1;
  localparam int PAD_W   = TDATA_WIDTH - SAMPLE_WIDTH;

  localparam logic [PW-1:0]           DEPTH_P   = PW'(DEPTH);
  localparam logic [PW-1:0]           FFT_LEN_P = PW'(FFT_LEN);
  localparam logic [PW-1:0]           HOP_P     = PW'(HOP);
  localparam logic [FFT_LEN_LOG2-1:0] LAST_IDX  = FFT_LEN_LOG2'(FFT_LEN - 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

  state_t                  state;
  // Pointers carry one bit beyond the buffer address so a full buffer differs from an empty one.
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           fs_ptr;
  logic [PW-1:0]           avail;
  logic [FFT_LEN_LOG2-1:0] rd_idx;
  logic [FFT_LEN_LOG2-1:0] next_idx;
  logic [AW-1:0]           rd_addr;
  logic                    drop;
  logic                    wr_en;
  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];

  // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    avail    = wr_ptr - fs_ptr;
    drop     = audio_sample_valid && (avail == DEPTH_P);
    wr_en    = audio_sample_valid && !drop;
    next_idx = rd_idx + FFT_LEN_LOG2'(1);
    rd_addr  = fs_ptr[AW-1:0];
    if (state == STREAM) rd_addr = fs_ptr[AW-1:0] + AW'(next_idx);
  end

  // NOTE: the sample buffer is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= in_sample;
  end

  // The output register doubles as the RAM read register: it only loads when the
  // current beat is taken, so a stalled beat holds and a flowing stream has no bubbles.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      fs_ptr        <= '0;
      rd_idx        <= '0;
      frame_count   <= '0;
      overrun       <= 1'b0;
      fft.fft_valid <= 1'b0;
      fft.fft_last  <= 1'b0;
      fft.fft_data  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (drop)  overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (avail >= FFT_LEN_P) state <= PRIME;
        end
        PRIME: begin
          fft.fft_data  <= {mem[rd_addr], {PAD_W{1'b0}}};
          fft.fft_valid <= 1'b1;
          fft.fft_last  <= (LAST_IDX == '0);
          rd_idx        <= '0;
          state         <= STREAM;
        end
        STREAM: begin
          // fft_valid is always high in STREAM, so ready alone marks an accepted beat.
          if (fft.fft_ready) begin
            if (rd_idx == LAST_IDX) begin
              fft.fft_valid <= 1'b0;
              fft.fft_last  <= 1'b0;
              fs_ptr        <= fs_ptr + HOP_P;
              frame_count   <= frame_count + 16'd1;
              state         <= IDLE;
            end else begin
              fft.fft_data <= {mem[rd_addr], {PAD_W{1'b0}}};
              fft.fft_last <= (next_idx == LAST_IDX);
              rd_idx       <= next_idx;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_frame_packer.sv
// Bench for fft_frame_packer: two instances (HOP=8 and HOP=4, 8-point frames) share one
// sample stream; a sample-list model predicts every beat, count and overrun.
module tb_fft_frame_packer;
  localparam int N = 8;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample = '0;
  logic       strobe = 1'b0;
  logic       ready_a = 1'b0;
  logic       ready_b = 1'b0;
  logic       rand_ready = 1'b0;
  logic [15:0] fc_a, fc_b;
  logic        ovr_a, ovr_b;

  fft_frame_packer_if #(.TDATA_WIDTH(16)) if_a ();
  fft_frame_packer_if #(.TDATA_WIDTH(16)) if_b ();
  assign if_a.fft_ready = ready_a;
  assign if_b.fft_ready = ready_b;

  fft_frame_packer #(.SAMPLE_WIDTH(8), .TDATA_WIDTH(16), .FFT_LEN_LOG2(3), .HOP(8)) u_a (
    .clk_in(clk), .rst_in(rst_n), .in_sample(sample), .audio_sample_valid(strobe),
    .fft(if_a), .frame_count(fc_a), .overrun(ovr_a));
  fft_frame_packer #(.SAMPLE_WIDTH(8), .TDATA_WIDTH(16), .FFT_LEN_LOG2(3), .HOP(4)) u_b (
    .clk_in(clk), .rst_in(rst_n), .in_sample(sample), .audio_sample_valid(strobe),
    .fft(if_b), .frame_count(fc_b), .overrun(ovr_b));

  always #5 clk = ~clk;

  logic [15:0] o_data [2];
  logic        o_vld [2];
  logic        o_last [2];
  logic        o_rdy [2];
  logic [15:0] o_fc [2];
  logic        o_ovr [2];
  assign o_data[0] = if_a.fft_data;  assign o_data[1] = if_b.fft_data;
  assign o_vld[0]  = if_a.fft_valid; assign o_vld[1]  = if_b.fft_valid;
  assign o_last[0] = if_a.fft_last;  assign o_last[1] = if_b.fft_last;
  assign o_rdy[0]  = ready_a;        assign o_rdy[1]  = ready_b;
  assign o_fc[0]   = fc_a;           assign o_fc[1]   = fc_b;
  assign o_ovr[0]  = ovr_a;          assign o_ovr[1]  = ovr_b;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the list of stored samples since reset; frame f is samples[f*hop +: N].
  logic [7:0]  smp [2][0:255];
  int          wr_m [2];
  int          done_m [2];
  int          beat_m [2];
  bit          ovr_m [2];
  bit          was_stall [2];
  logic [15:0] prev_data [2];
  logic        prev_last [2];
  logic [15:0] cap_data [2][0:63];
  logic        cap_last [2][0:63];
  int          cap_n [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      wr_m[d] = 0; done_m[d] = 0; beat_m[d] = 0; ovr_m[d] = 0;
      was_stall[d] = 0; cap_n[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    int hop;
    int done_pre;
    int idx;
    hop = (d == 0) ? 8 : 4;
    done_pre = done_m[d];
    if (was_stall[d]) begin
      check("hold_valid", 32'(o_vld[d]), 32'd1);
      check("hold_data", 32'(o_data[d]), 32'(prev_data[d]));
      check("hold_last", 32'(o_last[d]), 32'(prev_last[d]));
    end
    check("frame_count", 32'(o_fc[d]), 32'(done_m[d] % 65536));
    check("overrun", 32'(o_ovr[d]), 32'(ovr_m[d]));
    if (o_vld[d]) check("valid_with_frame_stored", 32'(wr_m[d] - done_m[d] * hop >= N), 32'd1);
    if (o_vld[d] && o_rdy[d]) begin
      idx = (done_m[d] * hop + beat_m[d]) % 256;
      check("beat_data", 32'(o_data[d]), 32'({smp[d][idx], 8'h00}));
      check("beat_last", 32'(o_last[d]), 32'(beat_m[d] == N - 1));
      if (cap_n[d] < 64) begin
        cap_data[d][cap_n[d]] = o_data[d];
        cap_last[d][cap_n[d]] = o_last[d];
      end
      cap_n[d]++;
      beat_m[d]++;
      if (beat_m[d] == N) begin
        beat_m[d] = 0;
        done_m[d]++;
      end
    end
    was_stall[d] = o_vld[d] && !o_rdy[d];
    prev_data[d] = o_data[d];
    prev_last[d] = o_last[d];
    if (strobe) begin
      if (wr_m[d] - done_pre * hop == D) ovr_m[d] = 1;
      else begin
        smp[d][wr_m[d] % 256] = sample;
        wr_m[d]++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        check("rst_valid", 32'(o_vld[d]), 32'd0);
        check("rst_data", 32'(o_data[d]), 32'd0);
        check("rst_last", 32'(o_last[d]), 32'd0);
      end
      model_reset();
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) begin
      ready_a = 1'($urandom_range(0, 1));
      ready_b = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send(input int v);
    sample = 8'(v);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    check("rst_async_valid_a", 32'(if_a.fft_valid), 32'd0);
    check("rst_fc_a", 32'(fc_a), 32'd0);
    check("rst_ovr_a", 32'(ovr_a), 32'd0);
    do_reset();

    // HOP=8 and HOP=4 with ready high, one sample every 4 cycles.
    ready_a = 1'b1; ready_b = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      send(i);
      if (i == 8) begin
        check("first_valid_e0", 32'(if_a.fft_valid), 32'd0);
        tick();
        check("first_valid_e1", 32'(if_a.fft_valid), 32'd0);
        tick();
        check("first_valid_e2_a", 32'(if_a.fft_valid), 32'd1);
        check("first_valid_e2_b", 32'(if_b.fft_valid), 32'd1);
        tick();
      end else begin
        repeat (3) tick();
      end
    end
    repeat (30) tick();
    check("t1_frames_a", 32'(fc_a), 32'd2);
    check("t1_frames_b", 32'(fc_b), 32'd3);
    check("t1_beats_a", 32'(cap_n[0]), 32'd16);
    check("t1_beats_b", 32'(cap_n[1]), 32'd24);
    check("t1_a_beat0", 32'(cap_data[0][0]), 32'h0100);
    check("t1_a_beat8", 32'(cap_data[0][8]), 32'h0900);
    check("t1_a_last7", 32'(cap_last[0][7]), 32'd1);
    check("t1_a_last6", 32'(cap_last[0][6]), 32'd0);
    check("t1_b_f2b0", 32'(cap_data[1][8]), 32'h0500);
    check("t1_b_f3b0", 32'(cap_data[1][16]), 32'h0900);
    check("t1_ovr_a", 32'(ovr_a), 32'd0);

    // Same stream under random 50% backpressure.
    do_reset();
    rand_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      send(i);
      repeat (3) tick();
    end
    repeat (200) tick();
    rand_ready = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1;
    repeat (40) tick();
    check("t3_frames_a", 32'(fc_a), 32'd2);
    check("t3_frames_b", 32'(fc_b), 32'd3);
    check("t3_a_last15", 32'(cap_last[0][15]), 32'd1);
    check("t3_a_beat15", 32'(cap_data[0][15]), 32'h1000);

    // Overrun: ready low, 17 back-to-back samples.
    ready_a = 1'b0; ready_b = 1'b0;
    do_reset();
    for (int i = 1; i <= 16; i++) send(i);
    check("t4_ovr_before", 32'(ovr_a), 32'd0);
    send(17);
    check("t4_ovr_after_a", 32'(ovr_a), 32'd1);
    check("t4_ovr_after_b", 32'(ovr_b), 32'd1);
    repeat (5) tick();
    ready_a = 1'b1; ready_b = 1'b1;
    repeat (60) tick();
    check("t4_frames_a", 32'(fc_a), 32'd2);
    check("t4_frames_b", 32'(fc_b), 32'd3);
    check("t4_a_beat15", 32'(cap_data[0][15]), 32'h1000);
    check("t4_ovr_sticky", 32'(ovr_a), 32'd1);

    // Reset pulse at beat 5 of a frame.
    do_reset();
    for (int i = 1; i <= 8; i++) send(i);
    for (int k = 0; k < 50 && cap_n[0] < 5; k++) tick();
    check("t5_reached_beat5", 32'(cap_n[0]), 32'd5);
    rst_n = 1'b0;
    #1;
    check("t5_async_valid_a", 32'(if_a.fft_valid), 32'd0);
    check("t5_async_valid_b", 32'(if_b.fft_valid), 32'd0);
    check("t5_async_fc", 32'(fc_a), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    for (int i = 101; i <= 108; i++) send(i);
    repeat (30) tick();
    check("t5_frames_a", 32'(fc_a), 32'd1);
    check("t5_beats_a", 32'(cap_n[0]), 32'd8);
    check("t5_a_beat0", 32'(cap_data[0][0]), 32'h6500);

    // Extreme sample values.
    do_reset();
    send(-128);
    send(127);
    for (int i = 1; i <= 6; i++) send(i);
    repeat (30) tick();
    check("t6_min", 32'(cap_data[0][0]), 32'h8000);
    check("t6_max", 32'(cap_data[0][1]), 32'h7F00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fft_frame_packer.md
# fft_frame_packer

Parametrised framer between the audio sample stream and the FFT core's AXI-Stream data input. It stores incoming samples in a circular buffer and emits FFT_LEN-point frames, one every HOP samples, so consecutive frames overlap. Frames are driven onto the FFT input with full tvalid/tready backpressure and a correct tlast. Sample drops on overrun are reported rather than silently corrupting frames.

## Interface
- SAMPLE_WIDTH, default 8: signed input sample width.
- TDATA_WIDTH, default 16: FFT input word width. Real part is the upper half, imaginary part the lower half. Requires SAMPLE_WIDTH <= TDATA_WIDTH/2.
- FFT_LEN_LOG2, default 12: frame length, FFT_LEN = 2^FFT_LEN_LOG2.
- HOP, default 2048: samples between frame starts. Legal range is 1..FFT_LEN.
- Buffer depth is fixed internally at DEPTH = 2*FFT_LEN (one inferred BRAM, 1-cycle read latency).

Ports:
- clk_in, input, 1: single clock for the block.
- rst_in, input, 1: reset, asynchronous, active-low.
- in_sample, input, SAMPLE_WIDTH: signed audio sample.
- audio_sample_valid, input, 1: single-cycle strobe; in_sample is captured on the same edge. The input is never stalled.
- fft_ready, input, 1: tready from the FFT core.
- fft_data, output, TDATA_WIDTH: tdata to the FFT core.
- fft_valid, output, 1: tvalid to the FFT core.
- fft_last, output, 1: tlast, asserted on the final beat of each frame.
- frame_count, output, 16: number of frames fully emitted; wraps modulo 2^16.
- overrun, output, 1: sticky flag, set when any sample has been dropped.

## Operation
- Write pointer `wr_ptr` (FFT_LEN_LOG2+1 bits, wraps modulo DEPTH) and frame start `fs_ptr` (same width).
- `avail = wr_ptr - fs_ptr` (modulo DEPTH, plus a full bit to distinguish full from empty). This is the count of stored samples from the current frame start.
- Write path: on audio_sample_valid with `avail < DEPTH`, store the sample at wr_ptr and increment wr_ptr. If `avail == DEPTH`, drop the sample, leave wr_ptr unchanged and set overrun.
- Output word: real half = in_sample left-aligned (sample << (TDATA_WIDTH/2 - SAMPLE_WIDTH)). Imaginary half = 0.
- FSM:
  - IDLE: go to PRIME when `avail >= FFT_LEN`.
  - PRIME: issue a read at `fs_ptr`, set `rd_idx = 0`, then go to STREAM.
  - STREAM: present the beat. On each fft_valid && fft_ready, increment rd_idx and present the next word.
  - After the beat with `rd_idx == FFT_LEN-1` is accepted: `fs_ptr += HOP`, `frame_count += 1`, then go to IDLE.
- Reads are addressed at `fs_ptr + rd_idx`. Prefetch uses a one-entry holding register so back-to-back beats need no bubble when fft_ready is held high.
- The writer may advance during STREAM. The reserved region is [fs_ptr, fs_ptr+DEPTH), so unread samples of the active frame are never overwritten.
- If `avail >= FFT_LEN` already holds on return to IDLE (frames queued), the next frame starts immediately. No frame is skipped; frames are separated by exactly HOP samples.
- With HOP = FFT_LEN, the output is non-overlapping, matching the original single-buffer behaviour.

## Timing
- Reset values while rst_in is low: fft_valid=0, fft_last=0, fft_data=0, frame_count=0, overrun=0, wr_ptr=fs_ptr=0, FSM=IDLE. Buffer contents are not reset.
- Reset asserted mid-frame: fft_valid drops asynchronously. After release, the partial frame is abandoned and the block waits for FFT_LEN fresh samples.
- First fft_valid appears 2 cycles after the rising edge that wrote the sample making `avail == FFT_LEN`.
- Throughput: one beat per cycle while fft_ready=1.
- Handshake: fft_valid, once high, stays high until accepted. fft_data and fft_last hold stable while fft_valid && !fft_ready.
- fft_last is high only on beat FFT_LEN-1.
- A drop-write and frame completion in the same cycle: fs_ptr advance takes effect the next cycle. That sample is still dropped (evaluated against pre-advance avail).
- Between frames, fft_valid is low for at least 1 cycle (PRIME).

## Test plan
- FFT_LEN_LOG2=3, HOP=8, fft_ready=1, samples 1..16 one every 4 cycles: exactly 2 frames, data 1..8 then 9..16 (×256 in the real half); fft_last on beats 8 and 16; frame_count=2; overrun=0.
- FFT_LEN_LOG2=3, HOP=4, samples 1..16: frames 1..8, 5..12, 9..16; frame_count=3.
- Same as the first case with fft_ready toggled by a random 50% pattern: data and tlast identical to the first case; fft_data held stable during every stall cycle.
- FFT_LEN_LOG2=3, HOP=8, fft_ready=0, 17 samples back-to-back: the 17th is dropped; overrun=1 from the cycle after the 17th strobe and stays 1. Releasing fft_ready yields frames 1..8, 9..16 intact.
- Reset pulse (rst_in low for 1 cycle) at beat 5 of a frame: fft_valid=0 immediately, frame_count=0. Next frame begins only after 8 new samples and contains those samples.
- SAMPLE_WIDTH=8, input -128: fft_data=16'h8000. Input 127: fft_data=16'h7F00.
